// File: rtl/mem_bridge.sv
// mem_bridge
// ----------
// Memory-side stage in front of the multicycle decoder/controller. Turns one
// decoder memory request (fetch, load word/byte, store word/byte) into a
// single Avalon-MM style transaction with waitrequest. Stalls the decoder
// while the access is in flight. Owns the instruction register and the
// memory data register.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_*               decoder request: valid, write, addr, wdata, byte,
//                       signed (LB vs LBU), ir (load result goes to IR)
//   stall               to decoder; request accepted or bus access pending
//   instr, mdr          instruction register, extended load data register
//   err_misaligned      one-cycle pulse after a rejected misaligned word access
//   err_timeout         one-cycle pulse after an abandoned bus access
//   avm_*               Avalon-MM master (big-endian lanes, bit3 = [31:24])
//
// Parameters:
//   TIMEOUT_CYCLES      waitrequest cycles tolerated before giving up (1..65535)
//   IR_RESET            reset value of the instruction register

module mem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] IR_RESET       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_byte,
  input  logic        req_signed,
  input  logic        req_ir,
  output logic        stall,
  output logic [31:0] instr,
  output logic [31:0] mdr,
  output logic        err_misaligned,
  output logic        err_timeout,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  typedef enum logic {IDLE, BUS} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [29:0] addr_q;
  logic [1:0]  lane_q;
  logic        byte_q;
  logic        signed_q;
  logic        ir_q;
  logic        write_q;
  logic        read_q;
  logic        wr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [15:0] cnt_q;
  logic [31:0] instr_q;
  logic [31:0] mdr_q;
  logic        err_mis_q;
  logic        err_to_q;

  logic        aligned_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [7:0]  load_byte_d;
  logic [31:0] load_ext_d;

  // Byte accesses may use any lane; word accesses must be word aligned.
  assign aligned_d = req_byte || (req_addr[1:0] == 2'b00);
  assign be_d      = req_byte ? (4'b1000 >> req_addr[1:0]) : 4'b1111;
  assign wdata_d   = req_byte ? {4{req_wdata[7:0]}} : req_wdata;

  // Big-endian lane select: address offset 0 lives in bits [31:24].
  always_comb begin
    load_byte_d = avm_readdata[7:0];
    case (lane_q)
      2'd0:    load_byte_d = avm_readdata[31:24];
      2'd1:    load_byte_d = avm_readdata[23:16];
      2'd2:    load_byte_d = avm_readdata[15:8];
      default: load_byte_d = avm_readdata[7:0];
    endcase
    load_ext_d = {{24{signed_q & load_byte_d[7]}}, load_byte_d};
  end

  // Combinational so the decoder freezes in the very cycle it asks.
  assign stall = ((state_q == IDLE) && req_valid && aligned_d) || (state_q == BUS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      lane_q    <= '0;
      byte_q    <= 1'b0;
      signed_q  <= 1'b0;
      ir_q      <= 1'b0;
      write_q   <= 1'b0;
      read_q    <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      be_q      <= '0;
      cnt_q     <= '0;
      instr_q   <= IR_RESET;
      mdr_q     <= '0;
      err_mis_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      err_mis_q <= 1'b0;
      err_to_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (aligned_d) begin
              state_q  <= BUS;
              addr_q   <= req_addr[31:2];
              lane_q   <= req_addr[1:0];
              byte_q   <= req_byte;
              signed_q <= req_signed;
              ir_q     <= req_ir;
              write_q  <= req_write;
              read_q   <= ~req_write;
              wr_q     <= req_write;
              wdata_q  <= wdata_d;
              be_q     <= be_d;
              cnt_q    <= '0;
            end else begin
              err_mis_q <= 1'b1;
            end
          end
        end
        BUS: begin
          if (!avm_waitrequest) begin
            // Completion takes priority over a coinciding timeout.
            state_q <= IDLE;
            read_q  <= 1'b0;
            wr_q    <= 1'b0;
            if (!write_q) begin
              if (ir_q)        instr_q <= avm_readdata;
              else if (byte_q) mdr_q   <= load_ext_d;
              else             mdr_q   <= avm_readdata;
            end
          end else if (cnt_q == TO_LAST) begin
            state_q  <= IDLE;
            read_q   <= 1'b0;
            wr_q     <= 1'b0;
            err_to_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr          = instr_q;
  assign mdr            = mdr_q;
  assign err_misaligned = err_mis_q;
  assign err_timeout    = err_to_q;
  assign avm_address    = {addr_q, 2'b00};
  assign avm_read       = read_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = be_q;

endmodule
